// File: rtl/spider_ctrl.sv
// rtl/spider_ctrl.sv - four-slot spider enemy controller
// Per-slot ALIVE/DYING/WAIT FSM with movement, hit-driven kill accounting and respawn.
module spider_ctrl #(
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int SPIDER_W       = 16,
   parameter int STEP           = 2,
   parameter int DROP           = 16,
   parameter int Y_TOP          = 40,
   parameter int DIE_FRAMES     = 8,
   parameter int RESPAWN_FRAMES = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic [3:0]  enemy_hit_flat,
   output logic [39:0] spider_x_flat,
   output logic [39:0] spider_y_flat,
   output logic [3:0]  spider_alive_flat,
   output logic [3:0]  spider_dying_flat,
   output logic        kill_pulse,
   output logic [7:0]  kill_count
);

   typedef enum logic [1:0] {S_ALIVE, S_DYING, S_WAIT} state_t;

   localparam logic [10:0] XMAX   = 11'(SCREEN_W - SPIDER_W);
   localparam logic [10:0] YMAX   = 11'(SCREEN_H - SPIDER_W);
   localparam logic [10:0] STEP_W = 11'(STEP);
   localparam logic [10:0] DROP_W = 11'(DROP);
   localparam logic [9:0]  YTOP_W = 10'(Y_TOP);
   localparam logic [7:0]  DIE_W  = 8'(DIE_FRAMES);
   localparam logic [7:0]  RESP_W = 8'(RESPAWN_FRAMES);

   state_t      state_q [4];
   state_t      state_d [4];
   logic [9:0]  x_q [4];
   logic [9:0]  x_d [4];
   logic [9:0]  y_q [4];
   logic [9:0]  y_d [4];
   logic        dir_q [4];   // 1 = moving right
   logic        dir_d [4];
   logic [7:0]  cnt_q [4];
   logic [7:0]  cnt_d [4];
   logic        kill_pulse_q, kill_pulse_d;
   logic [7:0]  kill_count_q, kill_count_d;
   logic [2:0]  n_hits;
   logic [8:0]  kill_sum;

   function automatic logic [9:0] home_x(input int i);
      return 10'(32 + i * 128);
   endfunction

   function automatic logic [9:0] drop_y(input logic [9:0] y);
      logic [10:0] ny;
      ny = {1'b0, y} + DROP_W;
      return (ny > YMAX) ? YTOP_W : ny[9:0];
   endfunction

   always_comb begin
      n_hits = 3'd0;
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         x_d[i]     = x_q[i];
         y_d[i]     = y_q[i];
         dir_d[i]   = dir_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_ALIVE: begin
               if (enemy_hit_flat[i]) begin
                  state_d[i] = S_DYING;
                  cnt_d[i]   = 8'd0;
                  n_hits     = n_hits + 3'd1;
               end else if (frame_tick) begin
                  if (dir_q[i]) begin
                     if (({1'b0, x_q[i]} + STEP_W) > XMAX) begin
                        x_d[i]   = XMAX[9:0];
                        dir_d[i] = 1'b0;
                        y_d[i]   = drop_y(y_q[i]);
                     end else begin
                        x_d[i] = x_q[i] + STEP_W[9:0];
                     end
                  end else begin
                     if ({1'b0, x_q[i]} < STEP_W) begin
                        x_d[i]   = 10'd0;
                        dir_d[i] = 1'b1;
                        y_d[i]   = drop_y(y_q[i]);
                     end else begin
                        x_d[i] = x_q[i] - STEP_W[9:0];
                     end
                  end
               end
            end
            S_DYING: begin
               if (frame_tick) begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
                  if (cnt_q[i] + 8'd1 == DIE_W) begin
                     state_d[i] = S_WAIT;
                     cnt_d[i]   = 8'd0;
                  end
               end
            end
            default: begin
               if (frame_tick) begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
                  if (cnt_q[i] + 8'd1 == RESP_W) begin
                     state_d[i] = S_ALIVE;
                     cnt_d[i]   = 8'd0;
                     x_d[i]     = home_x(i);
                     y_d[i]     = YTOP_W;
                     dir_d[i]   = (i % 2 == 0);
                  end
               end
            end
         endcase
      end
      kill_pulse_d = (n_hits != 3'd0);
      kill_sum     = {1'b0, kill_count_q} + {6'd0, n_hits};
      kill_count_d = kill_sum[8] ? 8'hFF : kill_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= S_ALIVE;
            x_q[i]     <= home_x(i);
            y_q[i]     <= YTOP_W;
            dir_q[i]   <= (i % 2 == 0);
            cnt_q[i]   <= 8'd0;
         end
         kill_pulse_q <= 1'b0;
         kill_count_q <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            x_q[i]     <= x_d[i];
            y_q[i]     <= y_d[i];
            dir_q[i]   <= dir_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         kill_pulse_q <= kill_pulse_d;
         kill_count_q <= kill_count_d;
      end
   end

   always_comb begin
      spider_x_flat     = '0;
      spider_y_flat     = '0;
      spider_alive_flat = '0;
      spider_dying_flat = '0;
      for (int i = 0; i < 4; i++) begin
         spider_x_flat[i*10 +: 10] = x_q[i];
         spider_y_flat[i*10 +: 10] = y_q[i];
         spider_alive_flat[i]      = (state_q[i] == S_ALIVE);
         spider_dying_flat[i]      = (state_q[i] == S_DYING);
      end
   end

   assign kill_pulse = kill_pulse_q;
   assign kill_count = kill_count_q;

endmodule

// File: tb/tb_spider_ctrl.sv
// tb/tb_spider_ctrl.sv - directed self-checking bench for spider_ctrl
module tb_spider_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic [3:0]  enemy_hit_flat = 4'd0;
   logic [39:0] spider_x_flat;
   logic [39:0] spider_y_flat;
   logic [3:0]  spider_alive_flat;
   logic [3:0]  spider_dying_flat;
   logic        kill_pulse;
   logic [7:0]  kill_count;

   int n_pass = 0;
   int n_total = 0;

   localparam logic [39:0] HOME_X = {10'd416, 10'd288, 10'd160, 10'd32};
   localparam logic [39:0] HOME_Y = {10'd40, 10'd40, 10'd40, 10'd40};

   spider_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .frame_tick        (frame_tick),
      .enemy_hit_flat    (enemy_hit_flat),
      .spider_x_flat     (spider_x_flat),
      .spider_y_flat     (spider_y_flat),
      .spider_alive_flat (spider_alive_flat),
      .spider_dying_flat (spider_dying_flat),
      .kill_pulse        (kill_pulse),
      .kill_count        (kill_count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      frame_tick = 1'b1;
      repeat (n) cyc();
      frame_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      cyc();
      n_total++;
      if (spider_alive_flat !== 4'b1111) $display("FAIL reset_alive got %b want 1111", spider_alive_flat);
      else n_pass++;
      n_total++;
      if (spider_dying_flat !== 4'b0000) $display("FAIL reset_dying got %b want 0000", spider_dying_flat);
      else n_pass++;
      n_total++;
      if (spider_x_flat !== HOME_X) $display("FAIL reset_x got %h want %h", spider_x_flat, HOME_X);
      else n_pass++;
      n_total++;
      if (spider_y_flat !== HOME_Y) $display("FAIL reset_y got %h want %h", spider_y_flat, HOME_Y);
      else n_pass++;
      n_total++;
      if (kill_count !== 8'd0 || kill_pulse !== 1'b0)
         $display("FAIL reset_kill got count=%0d pulse=%b want 0/0", kill_count, kill_pulse);
      else n_pass++;
   endtask

   task automatic test_move_bounce();
      logic [9:0] prev_y;
      logic [9:0] exp_y;
      bit         wrapped;
      do_reset();
      ticks(10);
      n_total++;
      if (spider_x_flat[9:0] !== 10'd52) $display("FAIL move_x0 got %0d want 52", spider_x_flat[9:0]);
      else n_pass++;
      n_total++;
      if (spider_x_flat[19:10] !== 10'd140) $display("FAIL move_x1 got %0d want 140", spider_x_flat[19:10]);
      else n_pass++;
      n_total++;
      if (spider_y_flat !== HOME_Y) $display("FAIL move_y got %h want %h", spider_y_flat, HOME_Y);
      else n_pass++;
      ticks(286);
      n_total++;
      if (spider_x_flat[9:0] !== 10'd624 || spider_y_flat[9:0] !== 10'd40)
         $display("FAIL edge_x0 got x=%0d y=%0d want 624/40", spider_x_flat[9:0], spider_y_flat[9:0]);
      else n_pass++;
      ticks(1);
      n_total++;
      if (spider_x_flat[9:0] !== 10'd624 || spider_y_flat[9:0] !== 10'd56)
         $display("FAIL bounce_x0 got x=%0d y=%0d want 624/56", spider_x_flat[9:0], spider_y_flat[9:0]);
      else n_pass++;
      ticks(1);
      n_total++;
      if (spider_x_flat[9:0] !== 10'd622) $display("FAIL after_bounce_x0 got %0d want 622", spider_x_flat[9:0]);
      else n_pass++;
      prev_y  = spider_y_flat[9:0];
      wrapped = 1'b0;
      for (int t = 0; t < 10000 && !wrapped; t++) begin
         ticks(1);
         if (spider_y_flat[9:0] !== prev_y) begin
            exp_y = (prev_y + 10'd16 > 10'd464) ? 10'd40 : prev_y + 10'd16;
            n_total++;
            if (spider_y_flat[9:0] !== exp_y)
               $display("FAIL drop_y0 got %0d want %0d", spider_y_flat[9:0], exp_y);
            else n_pass++;
            if (spider_y_flat[9:0] == 10'd40) wrapped = 1'b1;
            prev_y = spider_y_flat[9:0];
         end
      end
      n_total++;
      if (!wrapped) $display("FAIL y_wrap_timeout got nowrap want wrap to 40");
      else n_pass++;
   endtask

   task automatic test_hit_respawn();
      do_reset();
      enemy_hit_flat = 4'b0100;
      cyc();
      enemy_hit_flat = 4'b0000;
      n_total++;
      if (spider_alive_flat !== 4'b1011 || spider_dying_flat !== 4'b0100)
         $display("FAIL hit_state got alive=%b dying=%b want 1011/0100", spider_alive_flat, spider_dying_flat);
      else n_pass++;
      n_total++;
      if (kill_pulse !== 1'b1 || kill_count !== 8'd1)
         $display("FAIL hit_kill got pulse=%b count=%0d want 1/1", kill_pulse, kill_count);
      else n_pass++;
      cyc();
      n_total++;
      if (kill_pulse !== 1'b0) $display("FAIL pulse_width got %b want 0", kill_pulse);
      else n_pass++;
      ticks(7);
      n_total++;
      if (spider_dying_flat !== 4'b0100) $display("FAIL dying_7 got %b want 0100", spider_dying_flat);
      else n_pass++;
      ticks(1);
      n_total++;
      if (spider_dying_flat !== 4'b0000 || spider_alive_flat !== 4'b1011)
         $display("FAIL wait_entry got dying=%b alive=%b want 0000/1011", spider_dying_flat, spider_alive_flat);
      else n_pass++;
      enemy_hit_flat = 4'b0100;
      cyc();
      enemy_hit_flat = 4'b0000;
      n_total++;
      if (kill_pulse !== 1'b0 || kill_count !== 8'd1)
         $display("FAIL wait_hit got pulse=%b count=%0d want 0/1", kill_pulse, kill_count);
      else n_pass++;
      ticks(119);
      n_total++;
      if (spider_alive_flat !== 4'b1011) $display("FAIL wait_119 got %b want 1011", spider_alive_flat);
      else n_pass++;
      ticks(1);
      n_total++;
      if (spider_alive_flat !== 4'b1111) $display("FAIL respawn_alive got %b want 1111", spider_alive_flat);
      else n_pass++;
      n_total++;
      if (spider_x_flat[29:20] !== 10'd288 || spider_y_flat[29:20] !== 10'd40)
         $display("FAIL respawn_pos got x=%0d y=%0d want 288/40", spider_x_flat[29:20], spider_y_flat[29:20]);
      else n_pass++;
   endtask

   task automatic test_all_hit_with_tick();
      do_reset();
      enemy_hit_flat = 4'b1111;
      frame_tick = 1'b1;
      cyc();
      enemy_hit_flat = 4'b0000;
      frame_tick = 1'b0;
      n_total++;
      if (spider_alive_flat !== 4'b0000 || spider_dying_flat !== 4'b1111)
         $display("FAIL allhit_state got alive=%b dying=%b want 0000/1111", spider_alive_flat, spider_dying_flat);
      else n_pass++;
      n_total++;
      if (spider_x_flat !== HOME_X) $display("FAIL allhit_nomove got %h want %h", spider_x_flat, HOME_X);
      else n_pass++;
      n_total++;
      if (kill_count !== 8'd4 || kill_pulse !== 1'b1)
         $display("FAIL allhit_kill got count=%0d pulse=%b want 4/1", kill_count, kill_pulse);
      else n_pass++;
   endtask

   task automatic test_saturate_and_reset();
      do_reset();
      for (int r = 1; r <= 75; r++) begin
         enemy_hit_flat = 4'b1111;
         cyc();
         enemy_hit_flat = 4'b0000;
         if (r == 63) begin
            n_total++;
            if (kill_count !== 8'd252) $display("FAIL count_252 got %0d want 252", kill_count);
            else n_pass++;
         end
         if (r == 64) begin
            n_total++;
            if (kill_count !== 8'd255) $display("FAIL count_sat got %0d want 255", kill_count);
            else n_pass++;
         end
         ticks(128);
      end
      n_total++;
      if (kill_count !== 8'd255) $display("FAIL count_300 got %0d want 255", kill_count);
      else n_pass++;
      enemy_hit_flat = 4'b1111;
      cyc();
      enemy_hit_flat = 4'b0000;
      ticks(10);
      n_total++;
      if (spider_alive_flat !== 4'b0000 || spider_dying_flat !== 4'b0000)
         $display("FAIL pre_reset_wait got alive=%b dying=%b want 0000/0000", spider_alive_flat, spider_dying_flat);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (spider_alive_flat !== 4'b1111 || spider_dying_flat !== 4'b0000 || kill_count !== 8'd0 || kill_pulse !== 1'b0)
         $display("FAIL async_reset got alive=%b dying=%b count=%0d pulse=%b want 1111/0000/0/0",
                  spider_alive_flat, spider_dying_flat, kill_count, kill_pulse);
      else n_pass++;
      n_total++;
      if (spider_x_flat !== HOME_X || spider_y_flat !== HOME_Y)
         $display("FAIL async_reset_pos got x=%h y=%h want %h/%h", spider_x_flat, spider_y_flat, HOME_X, HOME_Y);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_move_bounce();
      test_hit_respawn();
      test_all_hit_with_tick();
      test_saturate_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
